// File: rtl/arb_rr_8.sv
// ----------------------------------------------------------------------------
// arb_rr_8 -- eight-requester round-robin arbiter with a bounded hold time.
//
// A grant is issued one cycle after a request is seen in IDLE. The arbiter
// then holds the grant in BUSY until the owner releases it or HOLD_MAX cycles
// have passed. A single GAP cycle follows every grant. The priority pointer
// moves one past the last owner, so a requester that was cut off by the limit
// goes to the back of the queue.
//
// Ports
//   clk          : clock, rising-edge active
//   rst_n        : asynchronous active-low reset
//   en           : allows a new selection in IDLE (never revokes a grant)
//   req[7:0]     : request bits, bit i = requester i
//   grant[7:0]   : registered one-hot grant, zero when nothing is granted
//   grant_id[2:0]: binary index of the current owner
//   grant_valid  : high exactly when grant is non-zero
//   timeout      : one-cycle pulse in the GAP that follows a limit revocation
// ----------------------------------------------------------------------------
module arb_rr_8 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        GAP  = 2'b10
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] grant_id_q, grant_id_d;
    logic       grant_valid_q, grant_valid_d;
    logic [7:0] grant_q, grant_d;
    logic       timeout_q, timeout_d;

    logic [3:0] pick_s;
    logic       release_s;
    logic       limit_s;

    // Returns {found, index} of the first set request searching ptr, ptr+1, ...
    // The 3-bit candidate wraps naturally modulo 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic       found;
        logic [2:0] idx;
        logic [2:0] cand;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = p + 3'(i);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    assign pick_s    = rr_pick(req, ptr_q);
    assign release_s = ~req[grant_id_q];
    assign limit_s   = (hold_cnt_q == HOLD_LAST);

    // Next-state, pointer, hold counter and output decisions.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && pick_s[3]) begin
                    state_d       = BUSY;
                    grant_id_d    = pick_s[2:0];
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = 4'd0;
                end else begin
                    grant_valid_d = 1'b0;
                end
            end
            BUSY: begin
                if (release_s || limit_s) begin
                    state_d       = GAP;
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_id_q + 3'd1;
                    // A release on the limit cycle is a normal release.
                    timeout_d     = ~release_s;
                end else begin
                    hold_cnt_d    = hold_cnt_q + 4'd1;
                end
            end
            GAP: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
                hold_cnt_d    = 4'd0;
            end
        endcase

        // The one-hot grant is always the decode of the owner index.
        if (grant_valid_d) begin
            grant_d = 8'd1 << grant_id_d;
        end else begin
            grant_d = 8'd0;
        end
    end

    // State and output registers, cleared immediately by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= 3'd0;
            hold_cnt_q    <= 4'd0;
            grant_id_q    <= 3'd0;
            grant_valid_q <= 1'b0;
            grant_q       <= 8'd0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            grant_q       <= grant_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_arb_rr_8.sv
module tb_arb_rr_8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int total;
    int bad;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] eg;
        logic       et;
    } vec_t;

    typedef struct {
        logic [7:0] g;
        logic       t;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    arb_rr_8 #(.HOLD_MAX(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic void add(input logic e, input logic [7:0] r,
                                input logic [7:0] eg, input logic et);
        vec_t v;
        v.en = e; v.req = r; v.eg = eg; v.et = et;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
    task automatic cycle(input logic e, input logic [7:0] r,
                         input logic [7:0] eg, input logic et, input string tag);
        exp_t x;
        en  = e;
        req = r;
        x.g = eg;
        x.t = et;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        chk({tag, "/grant"}, grant, x.g);
        chk({tag, "/valid"}, {7'd0, grant_valid}, {7'd0, (x.g != 8'd0)});
        chk({tag, "/timeout"}, {7'd0, timeout}, {7'd0, x.t});
        if (x.g != 8'd0) chk({tag, "/id"}, {5'd0, grant_id}, {5'd0, oh2idx(x.g)});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/grant"}, grant, 8'h00);
        chk({tag, "/valid"}, {7'd0, grant_valid}, 8'h00);
        chk({tag, "/id"}, {5'd0, grant_id}, 8'h00);
        chk({tag, "/timeout"}, {7'd0, timeout}, 8'h00);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;

        // Vector table: {en, req, expected grant, expected timeout} per cycle.
        // Single requester, released after three cycles; ptr ends at 1.
        add(1'b1, 8'h01, 8'h01, 1'b0);
        add(1'b1, 8'h01, 8'h01, 1'b0);
        add(1'b1, 8'h01, 8'h01, 1'b0);
        add(1'b1, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'h00, 8'h00, 1'b0);
        // Move ptr to 7, then wrap from 7 to 0; bit 0 during BUSY is ignored.
        add(1'b1, 8'h40, 8'h40, 1'b0);
        add(1'b1, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'h81, 8'h00, 1'b0);
        add(1'b1, 8'h81, 8'h80, 1'b0);
        add(1'b1, 8'h81, 8'h80, 1'b0);
        add(1'b1, 8'h01, 8'h00, 1'b0);
        add(1'b1, 8'h01, 8'h00, 1'b0);
        add(1'b1, 8'h01, 8'h01, 1'b0);
        add(1'b1, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'h00, 8'h00, 1'b0);
        // en low in IDLE blocks selection.
        add(1'b0, 8'h02, 8'h00, 1'b0);
        add(1'b0, 8'h02, 8'h00, 1'b0);
        // Grant 2, drop en, held to the limit; timeout; stays IDLE while en=0.
        add(1'b1, 8'h04, 8'h04, 1'b0);
        for (int i = 0; i < 7; i++) add(1'b0, 8'h04, 8'h04, 1'b0);
        add(1'b0, 8'h04, 8'h00, 1'b1);
        add(1'b0, 8'h04, 8'h00, 1'b0);
        add(1'b0, 8'h04, 8'h00, 1'b0);
        add(1'b0, 8'h04, 8'h00, 1'b0);
        // Timed-out requester 2 waits behind requester 3.
        add(1'b1, 8'h0C, 8'h08, 1'b0);
        add(1'b1, 8'h04, 8'h00, 1'b0);
        add(1'b1, 8'h04, 8'h00, 1'b0);
        add(1'b1, 8'h04, 8'h04, 1'b0);
        add(1'b1, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'h00, 8'h00, 1'b0);
        // Release exactly on the limit cycle: no timeout.
        add(1'b1, 8'h20, 8'h20, 1'b0);
        for (int i = 0; i < 7; i++) add(1'b1, 8'h20, 8'h20, 1'b0);
        add(1'b1, 8'h00, 8'h00, 1'b0);
        add(1'b1, 8'h00, 8'h00, 1'b0);

        // Reset values appear without a clock edge.
        #3;
        chk_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].en, vecs[i].req, vecs[i].eg, vecs[i].et, $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a grant to requester 4.
        cycle(1'b1, 8'h10, 8'h10, 1'b0, "busy10_a");
        cycle(1'b1, 8'h10, 8'h10, 1'b0, "busy10_b");
        cycle(1'b1, 8'h10, 8'h10, 1'b0, "busy10_c");
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        chk_reset_outputs("rst_held");
        rst_n = 1'b1;
        // ptr is back at 0, so requester 4 wins over 5.
        cycle(1'b1, 8'h30, 8'h10, 1'b0, "post_rst");
        cycle(1'b1, 8'h20, 8'h00, 1'b0, "post_rel");
        cycle(1'b1, 8'h00, 8'h00, 1'b0, "post_gap");

        // Fresh reset, then all requesters pending: full rotation with timeouts.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] g;
            g = 8'd1 << (k % 8);
            for (int c = 0; c < 8; c++) cycle(1'b1, 8'hFF, g, 1'b0, $sformatf("rot%0d_c%0d", k, c));
            cycle(1'b1, 8'hFF, 8'h00, 1'b1, $sformatf("rot%0d_to", k));
            cycle(1'b1, 8'hFF, 8'h00, 1'b0, $sformatf("rot%0d_gap", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
